pwm_quad: RTL and testbench
===========================

# pwm_quad

Four-channel, double-buffered PWM generator that consumes the duty bytes produced by the UART receive path and drives the board LEDs. Each channel has its own duty and phase. Each channel has a pending register, written at any time, and an active register, loaded only at the period boundary, so outputs never glitch mid-period. It sits directly downstream of the UART byte handler in the top level.

## Interface
- WIDTH, 8: counter, duty and phase width in bits.
- PRESCALE, 46: clock divider terminal count. The counter advances every PRESCALE+1 clocks. With 46 at 12 MHz the period is 47×256 clocks, about 997 Hz.

- clk  in  1  system clock, 12 MHz iCE_CLK.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run when high; hold the counter and blank the outputs when low.
- wr_en  in  1  single-cycle write strobe.
- wr_sel  in  3  write target: 0–3 selects duty of channel 0–3; 4–7 selects phase of channel 0–3.
- wr_data  in  WIDTH  write value.
- pwm_out  out  4  registered PWM outputs, bit i = channel i.
- period_tick  out  1  one-cycle pulse at each period start.

## Operation
- Prescaler:
  - pre counts 0..PRESCALE, then wraps to 0.
  - tick = enable && pre==PRESCALE. With PRESCALE=0, tick is asserted every enabled cycle.
- Base counter:
  - cnt increments on tick and wraps from 2^WIDTH−1 to 0.
  - wrap = tick && cnt==2^WIDTH−1.
- Writes:
  - wr_en loads wr_data into the pending register selected by wr_sel. The write always completes; there is no backpressure.
- Shadow load:
  - On wrap, every active register takes its pending value.
  - A write in the same cycle as wrap lands in pending only. Active takes the pre-write pending value, and the new value applies from the following period.
- Compare, per channel i:
  - local = (cnt + phase_act[i]) mod 2^WIDTH.
  - Next pwm_out[i] = enable && (local < duty_act[i]).
  - Duty 0 keeps the output always low. Duty 2^WIDTH−1 keeps it high for all but 1 count per period. 100% is not reachable by design.
- Disabled (enable=0):
  - pre and cnt are forced to 0, and pwm_out and period_tick are 0.
  - Active registers follow pending every cycle, so writes take effect immediately once the block is re-enabled.
- Re-enable:
  - Counting starts at cnt=0, pre=0.
  - The first period_tick comes at the first wrap, not at the enable edge.
- Reset, asynchronous at any time: pre, cnt, all pending and active registers, pwm_out and period_tick are cleared to 0.

## Timing
- pwm_out is registered. A compare evaluated on (cnt, active regs) in cycle t appears at the output in cycle t+1.
- period_tick is registered. It is high in the cycle after wrap, i.e. the first cycle in which cnt==0 and the newly loaded values are in effect.
- Period = (PRESCALE+1)·2^WIDTH clocks. Each output changes at most twice per period.
- Write-to-output latency while running: from 1 to (PRESCALE+1)·2^WIDTH + 1 clocks, depending on the position within the period.
- Write-to-output latency while disabled: it takes effect on the first enabled compare.
- Reset deassertion is synchronised by the top level; this block does not re-synchronise rst_n.

## Structure
- Package pwm_pkg holds:
  - the WIDTH default;
  - the wr_sel encodings SEL_DUTY0..3 = 0..3 and SEL_PHASE0..3 = 4..7;
  - the channel count NCH = 4.
- Sub-module pwm_chan, instantiated 4×, holds one channel's pending and active duty and phase, the shadow load, the phase add, the compare and the output flop.
- The top of pwm_quad owns the prescaler, the base counter, the wrap/tick generation and the wr_sel decode.

## Test plan
All scenarios use PRESCALE=0 and WIDTH=8 unless stated.
- Reset:
  - Assert rst_n low mid-period with ch0 duty=128 running → pwm_out=0 and period_tick=0 in the same cycle, without a clock.
  - After release with enable=1 → all outputs stay 0 because duties are 0.
- Basic duty:
  - Write ch0 duty=64 while disabled, then enable → pwm_out[0] high for exactly 64 of every 256 clocks.
  - Rising edge occurs 1 cycle after cnt==0; period_tick occurs every 256 clocks.
- Extremes:
  - ch1 duty=0 → never high.
  - ch2 duty=255 → low for exactly 1 clock per 256, namely the cycle after cnt==255.
- Phase:
  - ch3 duty=64, phase=128 → high exactly while the sampled cnt is in 128..191, 64 clocks.
  - ch0 unaffected.
- Shadow timing:
  - Running with ch0 duty=64, write duty=200 at cnt=100 → current period still gives 64 clocks high; next period gives 200.
  - Write duty=10 in the wrap cycle → next period still 200; the one after gives 10.
- Prescaler and enable:
  - PRESCALE=3 with duty=128 → period 1024 clocks, 512 high.
  - Drop enable mid-period → outputs 0 the next cycle.
  - Re-enable → cnt restarts at 0, and the first period_tick comes 1024 clocks later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the four-channel PWM generator: default width, write-select
// encodings and channel count.
package pwm_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned NCH           = 4;

  localparam logic [2:0] SEL_DUTY0  = 3'd0;
  localparam logic [2:0] SEL_DUTY1  = 3'd1;
  localparam logic [2:0] SEL_DUTY2  = 3'd2;
  localparam logic [2:0] SEL_DUTY3  = 3'd3;
  localparam logic [2:0] SEL_PHASE0 = 3'd4;
  localparam logic [2:0] SEL_PHASE1 = 3'd5;
  localparam logic [2:0] SEL_PHASE2 = 3'd6;
  localparam logic [2:0] SEL_PHASE3 = 3'd7;

  function automatic logic [2:0] sel_duty(int unsigned ch);
    return SEL_DUTY0 + 3'(ch);
  endfunction

  function automatic logic [2:0] sel_phase(int unsigned ch);
    return SEL_PHASE0 + 3'(ch);
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: pending/active duty and phase, shadow load at the period boundary,
// phase-shifted compare and the registered output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned Width = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             wrap_i,
  input  logic             duty_we_i,
  input  logic             phase_we_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [Width-1:0] cnt_i,
  output logic             pwm_o
);

  logic [Width-1:0] duty_pend_q, duty_pend_d;
  logic [Width-1:0] phase_pend_q, phase_pend_d;
  logic [Width-1:0] duty_act_q, duty_act_d;
  logic [Width-1:0] phase_act_q, phase_act_d;
  logic [Width-1:0] cnt_local;
  logic             load_act;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_pend_d  = duty_we_i ? wr_data_i : duty_pend_q;
    phase_pend_d = phase_we_i ? wr_data_i : phase_pend_q;

    // Active copies the pre-write pending value, so a write in the wrap cycle
    // only shows up one period later.
    load_act    = wrap_i || !enable_i;
    duty_act_d  = load_act ? duty_pend_q : duty_act_q;
    phase_act_d = load_act ? phase_pend_q : phase_act_q;

    cnt_local = cnt_i + phase_act_q;
    pwm_d     = enable_i && (cnt_local < duty_act_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_pend_q  <= '0;
      phase_pend_q <= '0;
      duty_act_q   <= '0;
      phase_act_q  <= '0;
      pwm_q        <= 1'b0;
    end else begin
      duty_pend_q  <= duty_pend_d;
      phase_pend_q <= phase_pend_d;
      duty_act_q   <= duty_act_d;
      phase_act_q  <= phase_act_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_quad.sv
// Four-channel double-buffered PWM generator: prescaler, shared base counter,
// wrap/tick generation and write decode feeding four pwm_chan instances.
module pwm_quad
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEFAULT,
  parameter int unsigned PRESCALE = 46
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_tick
);

  // Keep the prescaler at least one bit wide so PRESCALE=0 still elaborates.
  localparam int unsigned      PreW   = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(PRESCALE);
  localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};

  logic [PreW-1:0]  pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             wrap;
  logic             period_tick_q;
  logic [NCH-1:0]   duty_we;
  logic [NCH-1:0]   phase_we;

  always_comb begin
    tick  = enable && (pre_q == PreMax);
    wrap  = tick && (cnt_q == CntMax);
    pre_d = '0;
    cnt_d = '0;
    if (enable) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
      cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;
    end
  end

  always_comb begin
    duty_we  = '0;
    phase_we = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      duty_we[i]  = wr_en && (wr_sel == sel_duty(i));
      phase_we[i] = wr_en && (wr_sel == sel_phase(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      period_tick_q <= wrap;
    end
  end

  assign period_tick = period_tick_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    pwm_chan #(
      .Width(WIDTH)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .enable_i  (enable),
      .wrap_i    (wrap),
      .duty_we_i (duty_we[gi]),
      .phase_we_i(phase_we[gi]),
      .wr_data_i (wr_data),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_pwm_quad.sv
// Bench for pwm_quad: two instances (PRESCALE 0 and 3) on shared inputs, checked each
// cycle against a period-arithmetic reference model plus directed duty/timing counts.
module tb_pwm_quad;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] pwm_a, pwm_b;
  logic       tick_a, tick_b;

  always #5 clk = ~clk;

  pwm_quad #(
    .WIDTH   (8),
    .PRESCALE(0)
  ) u_dut_p0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .pwm_out    (pwm_a),
    .period_tick(tick_a)
  );

  pwm_quad #(
    .WIDTH   (8),
    .PRESCALE(3)
  ) u_dut_p3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .pwm_out    (pwm_b),
    .period_tick(tick_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: position in the period is derived from the number of enabled
  // clocks since (re)enable; index 0 models PRESCALE=0, index 1 PRESCALE=3.
  int unsigned pre_n[2] = '{1, 4};
  int unsigned m_k[2];
  int unsigned m_pd[2][4];
  int unsigned m_pp[2][4];
  int unsigned m_ad[2][4];
  int unsigned m_ap[2][4];
  logic [3:0]  m_pwm[2];
  logic        m_tick[2];

  int hi_cnt[2][4];
  bit tick_seen[2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_k[s]    = 0;
      m_pwm[s]  = '0;
      m_tick[s] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_pd[s][i] = 0;
        m_pp[s][i] = 0;
        m_ad[s][i] = 0;
        m_ap[s][i] = 0;
      end
    end
  endtask

  task automatic model_step(input int s);
    int unsigned per, c;
    bit          wrapped;
    if (!rst_n) return;
    per = pre_n[s] * 256;
    if (enable) begin
      c       = (m_k[s] / pre_n[s]) % 256;
      wrapped = (m_k[s] % per) == per - 1;
      for (int i = 0; i < 4; i++) m_pwm[s][i] = ((c + m_ap[s][i]) % 256) < m_ad[s][i];
      m_tick[s] = wrapped;
      if (wrapped) begin
        m_ad[s] = m_pd[s];
        m_ap[s] = m_pp[s];
      end
      m_k[s]++;
    end else begin
      m_pwm[s]  = '0;
      m_tick[s] = 1'b0;
      m_ad[s]   = m_pd[s];
      m_ap[s]   = m_pp[s];
      m_k[s]    = 0;
    end
    if (wr_en) begin
      if (wr_sel < 4) m_pd[s][wr_sel] = wr_data;
      else m_pp[s][wr_sel - 4] = wr_data;
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("pwm_p0", pwm_a, m_pwm[0]);
    check("tick_p0", tick_a, m_tick[0]);
    check("pwm_p3", pwm_b, m_pwm[1]);
    check("tick_p3", tick_b, m_tick[1]);
    for (int i = 0; i < 4; i++) begin
      hi_cnt[0][i] += pwm_a[i];
      hi_cnt[1][i] += pwm_b[i];
    end
    if (tick_a) tick_seen[0] = 1'b1;
    if (tick_b) tick_seen[1] = 1'b1;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) tick_clk();
  endtask

  task automatic clear_counts();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) hi_cnt[s][i] = 0;
  endtask

  task automatic write(input logic [2:0] sel, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    tick_clk();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int s, input int bound, output int n);
    n            = 0;
    tick_seen[0] = 1'b0;
    tick_seen[1] = 1'b0;
    while (!tick_seen[s] && n < bound) begin
      tick_clk();
      n++;
    end
    if (!tick_seen[s]) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    model_reset();
    clear_counts();
    run(3);
    rst_n = 1'b1;
    run(2);

    // Reset mid-period with ch0 running at duty 128.
    write(3'd0, 8'd128);
    enable = 1'b1;
    run(70);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pwm", pwm_a, 0);
    check("rst_async_tick", tick_a, 0);
    check("rst_async_pwm_p3", pwm_b, 0);
    model_reset();
    run(2);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    run(300);
    check("post_rst_hi", hi_cnt[0][0] + hi_cnt[0][1] + hi_cnt[0][2] + hi_cnt[0][3], 0);

    // Basic duty written while disabled.
    enable = 1'b0;
    tick_clk();
    write(3'd0, 8'd64);
    enable = 1'b1;
    wait_tick(0, 300, n);
    check("first_tick_p0", n, 256);
    clear_counts();
    wait_tick(0, 300, n);
    check("tick_gap_p0", n, 256);
    check("duty64_hi", hi_cnt[0][0], 64);

    // Extremes and phase; settle one period so the new values are active.
    write(3'd1, 8'd0);
    write(3'd2, 8'd255);
    write(3'd3, 8'd64);
    write(3'd7, 8'd128);
    wait_tick(0, 300, n);
    clear_counts();
    wait_tick(0, 300, n);
    check("duty0_hi", hi_cnt[0][1], 0);
    check("duty255_hi", hi_cnt[0][2], 255);
    check("phase_hi", hi_cnt[0][3], 64);
    check("ch0_unaffected", hi_cnt[0][0], 64);

    // Shadow: write 200 at cnt=100, then 10 in the wrap cycle.
    clear_counts();
    run(100);
    write(3'd0, 8'd200);
    run(155);
    check("shadow_cur", hi_cnt[0][0], 64);
    check("shadow_cur_tick", tick_a, 1);
    clear_counts();
    run(255);
    write(3'd0, 8'd10);
    check("shadow_next", hi_cnt[0][0], 200);
    clear_counts();
    run(256);
    check("wrap_write_next", hi_cnt[0][0], 200);
    clear_counts();
    run(256);
    check("wrap_write_after", hi_cnt[0][0], 10);

    // Prescaler: PRESCALE=3 instance, duty 128.
    write(3'd0, 8'd128);
    wait_tick(1, 1100, n);
    wait_tick(1, 1100, n);
    clear_counts();
    wait_tick(1, 1100, n);
    check("tick_gap_p3", n, 1024);
    check("duty128_p3_hi", hi_cnt[1][0], 512);

    // Disable mid-period, then re-enable.
    run(300);
    enable = 1'b0;
    tick_clk();
    check("dis_pwm_p0", pwm_a, 0);
    check("dis_pwm_p3", pwm_b, 0);
    run(10);
    enable = 1'b1;
    wait_tick(1, 1100, n);
    check("reen_first_tick_p3", n, 1024);

    // Randomized writes and enable toggles against the model.
    for (int j = 0; j < 4000; j++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) begin
        wr_en   = 1'b1;
        wr_sel  = 3'($urandom_range(0, 7));
        wr_data = 8'($urandom);
      end
      tick_clk();
      wr_en = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
